// File: rtl/vexriscv_dbus_ram_slave.sv
// Local data RAM answering the VexRiscv simple dBus (cmd/rsp).
// Ports: clk, arst (async, active-high), dBus_cmd_* command channel,
//   dBus_rsp_* read response (single-cycle, no back-pressure),
//   err_sticky (latched on any errored access until arst).
// Optional: define DBUS_SLV_MISALIGN_ERR_EN to reject misaligned
//   half/word accesses instead of force-aligning them.
module vexriscv_dbus_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SIZE_BYTES  = 4096,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic        dBus_rsp_error,
  output logic [31:0] dBus_rsp_data,
  output logic        err_sticky
);

  localparam int AW    = $clog2(SIZE_BYTES);
  localparam int WORDS = SIZE_BYTES / 4;
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [AW-3:0] idx_q;
  logic        err_q;
  logic [31:0] mem [WORDS];

  logic [32:0] off;
  logic        in_range;
  logic        mis;
  logic        bad;
  logic        fire;
  logic        wr_en;
  logic [AW-3:0] idx;
  logic [AW-3:0] rd_idx;
  logic [3:0]  be;
  logic [31:0] rd_word;

  // 33-bit offset: bit 32 is the borrow, i.e. address below base.
  assign off = {1'b0, dBus_cmd_payload_address}
             - {1'b0, BASE_ADDR};
  assign in_range = ~off[32]
                 && (off[31:0] < 32'(SIZE_BYTES));
  assign idx = off[AW-1:2];

`ifdef DBUS_SLV_MISALIGN_ERR_EN
  assign mis =
    ((dBus_cmd_payload_size == 2'd1)
      && dBus_cmd_payload_address[0])
    || ((dBus_cmd_payload_size == 2'd2)
      && (dBus_cmd_payload_address[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign bad = ~in_range
            || (dBus_cmd_payload_size == 2'd3)
            || mis;

  // Ready is forced low while reset is held.
  assign dBus_cmd_ready = (state == S_IDLE) && !arst;
  assign fire  = dBus_cmd_valid && dBus_cmd_ready;
  assign wr_en = fire && dBus_cmd_payload_wr && !bad;

  always_comb begin
    be = 4'b0000;
    case (dBus_cmd_payload_size)
      2'd0: be = 4'b0001 << dBus_cmd_payload_address[1:0];
      2'd1: be = dBus_cmd_payload_address[1] ? 4'b1100
                                             : 4'b0011;
      2'd2: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) begin
          mem[idx][8*n +: 8] <= dBus_cmd_payload_data[8*n +: 8];
        end
      end
    end
  end

  // No write can be accepted outside IDLE, so the held index
  // still addresses the data the read saw at acceptance.
  assign rd_idx  = (state == S_IDLE) ? idx : idx_q;
  assign rd_word = mem[rd_idx];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      idx_q          <= '0;
      err_q          <= 1'b0;
      dBus_rsp_ready <= 1'b0;
      dBus_rsp_error <= 1'b0;
      dBus_rsp_data  <= 32'd0;
      err_sticky     <= 1'b0;
    end else begin
      if (fire && bad) begin
        err_sticky <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          dBus_rsp_ready <= 1'b0;
          dBus_rsp_error <= 1'b0;
          dBus_rsp_data  <= 32'd0;
          if (fire && !dBus_cmd_payload_wr) begin
            idx_q <= idx;
            err_q <= bad;
            if (WAIT_CYCLES == 0) begin
              state          <= S_RESP;
              dBus_rsp_ready <= 1'b1;
              dBus_rsp_error <= bad;
              dBus_rsp_data  <= bad ? 32'd0 : rd_word;
            end else begin
              state <= S_WAIT;
              cnt   <= WLOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state          <= S_RESP;
            dBus_rsp_ready <= 1'b1;
            dBus_rsp_error <= err_q;
            dBus_rsp_data  <= err_q ? 32'd0 : rd_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state          <= S_IDLE;
          dBus_rsp_ready <= 1'b0;
          dBus_rsp_error <= 1'b0;
          dBus_rsp_data  <= 32'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vexriscv_dbus_ram_slave.sv
// Bench for vexriscv_dbus_ram_slave: two instances (0 and 3
// wait cycles), directed vectors, random ops vs a byte model.
module tb_vexriscv_dbus_ram_slave;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int SIZE = 4096;
`ifdef DBUS_SLV_MISALIGN_ERR_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic cv [2];
  logic wr [2];
  logic cr [2];
  logic rr [2];
  logic re [2];
  logic st [2];
  logic [31:0] ad [2];
  logic [31:0] dt [2];
  logic [31:0] rd [2];
  logic [1:0]  sz [2];

  always #5 clk = ~clk;

  vexriscv_dbus_ram_slave #(
    .BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_CYCLES(0)
  ) u0 (
    .clk(clk), .arst(arst),
    .dBus_cmd_valid(cv[0]), .dBus_cmd_ready(cr[0]),
    .dBus_cmd_payload_wr(wr[0]),
    .dBus_cmd_payload_address(ad[0]),
    .dBus_cmd_payload_data(dt[0]),
    .dBus_cmd_payload_size(sz[0]),
    .dBus_rsp_ready(rr[0]), .dBus_rsp_error(re[0]),
    .dBus_rsp_data(rd[0]), .err_sticky(st[0])
  );

  vexriscv_dbus_ram_slave #(
    .BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_CYCLES(3)
  ) u3 (
    .clk(clk), .arst(arst),
    .dBus_cmd_valid(cv[1]), .dBus_cmd_ready(cr[1]),
    .dBus_cmd_payload_wr(wr[1]),
    .dBus_cmd_payload_address(ad[1]),
    .dBus_cmd_payload_data(dt[1]),
    .dBus_cmd_payload_size(sz[1]),
    .dBus_rsp_ready(rr[1]), .dBus_rsp_error(re[1]),
    .dBus_rsp_data(rd[1]), .err_sticky(st[1])
  );

  int checks = 0;
  int fails = 0;
  logic [7:0] mb [2][SIZE];
  bit stm [2];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    bit          bad;
    logic [31:0] ex;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(bit w, logic [31:0] a,
      logic [31:0] d, logic [1:0] s, bit bad,
      logic [31:0] ex);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s;
    v.bad = bad; v.ex = ex;
    return v;
  endfunction

  function automatic int wt_of(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference: an access covers 2**size bytes
  // starting at the offset rounded down to the access size.
  function automatic void ref_op(input int d, input bit w,
      input logic [31:0] a, input logic [31:0] da,
      input logic [1:0] s, output bit bad,
      output logic [31:0] ex);
    longint off;
    int n;
    int s0;
    off = longint'(a) - longint'(BASE);
    n = 1 << s;
    bad = (off < 0) || (off >= SIZE) || (s == 2'd3);
    if (MIS && (s != 2'd3) && ((off % n) != 0)) bad = 1'b1;
    ex = 32'd0;
    if (bad) begin
      stm[d] = 1'b1;
    end else if (w) begin
      s0 = int'(off - (off % n));
      for (int b = s0; b < s0 + n; b++)
        mb[d][b] = da[8*(b%4) +: 8];
    end else begin
      s0 = int'(off - (off % 4));
      ex = {mb[d][s0+3], mb[d][s0+2], mb[d][s0+1], mb[d][s0]};
    end
  endfunction

  task automatic do_cmd(input int d, input bit w,
      input logic [31:0] a, input logic [31:0] da,
      input logic [1:0] s, output logic e,
      output logic [31:0] r);
    int n;
    bit got;
    e = 1'b0;
    r = 32'd0;
    n = 0;
    @(negedge clk);
    while (!cr[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cr[d]) begin
      checks++;
      fails++;
      $display("FAIL cmd_ready_timeout dut%0d: got 0 expected 1", d);
      return;
    end
    cv[d] = 1'b1; wr[d] = w; ad[d] = a; dt[d] = da; sz[d] = s;
    @(posedge clk);
    #1 cv[d] = 1'b0;
    if (!w) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        if (rr[d]) begin
          got = 1'b1;
          e = re[d];
          r = rd[d];
        end
      end
      chk($sformatf("rsp_latency_dut%0d", d), 32'(n),
          32'(wt_of(d) + 1));
      @(negedge clk);
      chk($sformatf("rsp_single_dut%0d", d), rr[d], 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic e;
    logic [31:0] r;
    logic [31:0] ex;
    logic [31:0] a;
    bit bad;
    bit w;
    bit st_exp;
    int n;
    int p;
    int pulses;

    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'd0;
      dt[d] = 32'd0; sz[d] = 2'd0; stm[d] = 1'b0;
    end

    tv.push_back(mk(1, 32'h1000_0000, 32'hDEAD_BEEF, 2, 0, 0));
    tv.push_back(mk(0, 32'h1000_0000, 0, 2, 0, 32'hDEAD_BEEF));
    tv.push_back(mk(1, 32'h1000_0004, 32'h1122_3344, 2, 0, 0));
    tv.push_back(mk(0, 32'h1000_0004, 0, 2, 0, 32'h1122_3344));
    tv.push_back(mk(1, 32'h1000_0007, 32'h5A5A_5A5A, 0, 0, 0));
    tv.push_back(mk(0, 32'h1000_0004, 0, 2, 0, 32'h5A22_3344));
    tv.push_back(mk(1, 32'h1000_0006, 32'hA5A5_A5A5, 1, 0, 0));
    tv.push_back(mk(0, 32'h1000_0004, 0, 2, 0, 32'hA5A5_3344));
    tv.push_back(mk(0, 32'h1000_0002, 0, 2, MIS,
                    MIS ? 32'd0 : 32'hDEAD_BEEF));
    tv.push_back(mk(1, 32'h1000_0005, 32'hCCCC_CCCC, 1, MIS, 0));
    tv.push_back(mk(0, 32'h1000_0004, 0, 2, 0,
                    MIS ? 32'hA5A5_3344 : 32'hA5A5_CCCC));
    tv.push_back(mk(0, 32'h1000_0000, 0, 0, 0, 32'hDEAD_BEEF));
    tv.push_back(mk(0, 32'h0FFF_FFFC, 0, 2, 1, 0));
    tv.push_back(mk(0, 32'h1000_1000, 0, 2, 1, 0));
    tv.push_back(mk(0, 32'hFFFF_FFFC, 0, 2, 1, 0));
    tv.push_back(mk(1, 32'h1000_1000, 32'h7777_7777, 2, 1, 0));
    tv.push_back(mk(0, 32'h1000_0000, 0, 2, 0, 32'hDEAD_BEEF));
    tv.push_back(mk(1, 32'h1000_0000, 32'h9999_9999, 3, 1, 0));
    tv.push_back(mk(0, 32'h1000_0000, 0, 2, 0, 32'hDEAD_BEEF));
    tv.push_back(mk(0, 32'h1000_0000, 0, 3, 1, 0));
    tv.push_back(mk(1, 32'h1000_0FFC, 32'h0BAD_F00D, 2, 0, 0));
    tv.push_back(mk(1, 32'h1000_0FFF, 32'h1212_1212, 0, 0, 0));
    tv.push_back(mk(0, 32'h1000_0FFC, 0, 2, 0, 32'h12AD_F00D));

    // reset state
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_cmd_ready%0d", d), cr[d], 1'b0);
      chk($sformatf("rst_rsp_ready%0d", d), rr[d], 1'b0);
      chk($sformatf("rst_rsp_error%0d", d), re[d], 1'b0);
      chk($sformatf("rst_rsp_data%0d", d), rd[d], 32'd0);
      chk($sformatf("rst_sticky%0d", d), st[d], 1'b0);
    end
    repeat (2) @(negedge clk);
    arst = 1'b0;
    #1;
    chk("rel_cmd_ready0", cr[0], 1'b1);
    chk("rel_cmd_ready1", cr[1], 1'b1);

    // directed vectors, zero wait states
    st_exp = 1'b0;
    foreach (tv[i]) begin
      do_cmd(0, tv[i].w, tv[i].a, tv[i].d, tv[i].s, e, r);
      st_exp = st_exp | tv[i].bad;
      if (!tv[i].w) begin
        chk($sformatf("vec%0d_err", i), e, tv[i].bad);
        chk($sformatf("vec%0d_data", i), r, tv[i].ex);
      end
      chk($sformatf("vec%0d_sticky", i), st[0], st_exp);
    end
    stm[0] = st_exp;

    // random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 17; i++) begin
        n = (i == 16) ? 1023 : i;
        a = BASE + 32'(n * 4);
        ex = $urandom;
        ref_op(d, 1'b1, a, ex, 2'd2, bad, r);
        do_cmd(d, 1'b1, a, ex, 2'd2, e, r);
      end
      for (int i = 0; i < 150; i++) begin
        p = $urandom_range(0, 9);
        if (p < 8)
          a = BASE + 32'($urandom_range(0, 63));
        else if (p == 8)
          a = BASE + 32'(SIZE - 4) + 32'($urandom_range(0, 7));
        else
          a = BASE - 32'($urandom_range(1, 8));
        w = bit'($urandom_range(0, 1));
        dt[d] = $urandom;
        ex = dt[d];
        p = $urandom_range(0, 3);
        ref_op(d, w, a, ex, 2'(p), bad, r);
        do_cmd(d, w, a, ex, 2'(p), e, ex);
        if (!w) begin
          chk($sformatf("rnd%0d_%0d_err", d, i), e, bad);
          chk($sformatf("rnd%0d_%0d_data", d, i), ex, r);
        end
        chk($sformatf("rnd%0d_%0d_sticky", d, i), st[d], stm[d]);
      end
    end

    // three wait states: cycle-exact response window
    @(negedge clk);
    n = 0;
    while (!cr[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w3_idle_ready", cr[1], 1'b1);
    ref_op(1, 1'b0, BASE, 32'd0, 2'd2, bad, ex);
    cv[1] = 1'b1; wr[1] = 1'b0; ad[1] = BASE; sz[1] = 2'd2;
    @(posedge clk);
    #1;
    wr[1] = 1'b1; ad[1] = BASE + 32'd20;
    dt[1] = 32'hBAD0_BAD0; sz[1] = 2'd2;
    for (int c = 11; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("w3_cmd_ready_c%0d", c), cr[1], 1'b0);
      chk($sformatf("w3_rsp_ready_c%0d", c), rr[1], c == 14);
      if (c == 14) chk("w3_rsp_data", rd[1], ex);
    end
    @(negedge clk);
    chk("w3_cmd_ready_c15", cr[1], 1'b1);
    ref_op(1, 1'b0, BASE + 32'd20, 32'd0, 2'd2, bad, ex);
    wr[1] = 1'b0; ad[1] = BASE + 32'd20;
    @(posedge clk);
    #1 cv[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("w3_b2b_rsp_k%0d", k), rr[1], k == 4);
    end
    chk("w3_held_write_ignored", rd[1], ex);

    // error then reset during WAIT
    do_cmd(1, 1'b0, BASE + 32'(SIZE), 32'd0, 2'd2, e, r);
    chk("oor_err", e, 1'b1);
    chk("oor_data", r, 32'd0);
    chk("oor_sticky", st[1], 1'b1);
    @(negedge clk);
    n = 0;
    while (!cr[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    cv[1] = 1'b1; wr[1] = 1'b0; ad[1] = BASE + 32'd4; sz[1] = 2'd2;
    @(posedge clk);
    #1 cv[1] = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    #1;
    chk("arst_cmd_ready1", cr[1], 1'b0);
    chk("arst_cmd_ready0", cr[0], 1'b0);
    chk("arst_sticky1", st[1], 1'b0);
    chk("arst_sticky0", st[0], 1'b0);
    chk("arst_rsp_ready", rr[1], 1'b0);
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("arst_rel_ready", cr[1], 1'b1);
    stm[0] = 1'b0;
    stm[1] = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (rr[1]) pulses++;
    end
    chk("arst_no_rsp", 32'(pulses), 32'd0);
    ref_op(1, 1'b0, BASE + 32'd4, 32'd0, 2'd2, bad, ex);
    do_cmd(1, 1'b0, BASE + 32'd4, 32'd0, 2'd2, e, r);
    chk("arst_ram_kept_err", e, 1'b0);
    chk("arst_ram_kept", r, ex);
    chk("arst_sticky_after", st[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/vexriscv_dbus_ram_slave.md
Name: vexriscv_dbus_ram_slave

Overview:
- Responder for the VexRiscv "simple" data bus (dBus cmd/rsp).
- Sits on the core's dBus port in the CPU tile as a local data RAM.
- Accepts read/write commands, applies byte-lane writes, and returns read data after a configurable wait-state count.
- Flags out-of-range and illegal accesses via rsp_error and a sticky error output.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of first RAM location
- SIZE_BYTES, 4096, RAM size in bytes; power of two, multiple of 4
- WAIT_CYCLES, 0, extra cycles between read acceptance and response (0..15)

Ports:
- clk  input  1  clock, all logic on rising edge
- arst  input  1  asynchronous reset, active-high
- dBus_cmd_valid  input  1  command valid
- dBus_cmd_ready  output  1  slave can accept command this cycle
- dBus_cmd_payload_wr  input  1  1=write, 0=read
- dBus_cmd_payload_address  input  32  byte address
- dBus_cmd_payload_data  input  32  write data; core replicates byte/half across lanes
- dBus_cmd_payload_size  input  2  0=byte, 1=half, 2=word, 3=illegal
- dBus_rsp_ready  output  1  read response valid, single-cycle pulse (no back-pressure)
- dBus_rsp_error  output  1  response carries error; valid only with dBus_rsp_ready
- dBus_rsp_data  output  32  read data, full aligned word
- err_sticky  output  1  set on any errored access; cleared only by arst

Behaviour:
- Reset values:
  - dBus_cmd_ready=0 during arst, 1 on the first cycle after release.
  - dBus_rsp_ready=0, dBus_rsp_error=0, dBus_rsp_data=0, err_sticky=0, FSM=IDLE.
  - RAM contents are not reset.
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready. Payload is sampled only at acceptance.
- FSM states:
  - IDLE: cmd_ready=1. A write is accepted and stays in IDLE. A read is accepted and goes to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: cmd_ready=0; 4-bit counter loaded with WAIT_CYCLES-1 and decremented each cycle; goes to RESP when counter=0.
  - RESP: cmd_ready=0; rsp_ready=1 for exactly one cycle with data/error; goes to IDLE.
- Read latency: response arrives WAIT_CYCLES+1 cycles after acceptance.
  - Back-to-back reads: one read per WAIT_CYCLES+2 cycles.
  - Back-to-back writes: one per cycle.
- Decode:
  - in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR+SIZE_BYTES), using 33-bit arithmetic (no wrap at 2^32).
  - word index = (addr-BASE_ADDR)[log2(SIZE_BYTES)-1:2].
- Write lane enables:
  - size=0: lane addr[1:0].
  - size=1: lanes {addr[1],0} and {addr[1],1}.
  - size=2: all four lanes.
  - Lane n writes payload_data[8n+7:8n].
- Read returns the whole word at the word index. The core extracts bytes/halves itself.
- Errors:
  - Out-of-range read: RESP with rsp_error=1, rsp_data=0, err_sticky<=1.
  - Out-of-range write: dropped, RAM unchanged, err_sticky<=1, no response (writes never respond).
  - size=3: treated as error as above regardless of address.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1.
- arst mid-transaction: FSM returns to IDLE immediately and any pending read response is discarded (never emitted). RAM writes already committed remain.
- cmd_valid with unchanged payload while cmd_ready=0: no effect.

Optional Feature:
- Macro: DBUS_SLV_MISALIGN_ERR_EN.
- Defined: misaligned accesses are errors, handled exactly like out-of-range (read errors, write dropped, sticky set).
  - Misaligned means size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
- Undefined: low address bits below access size are ignored.
  - Half uses addr[1] only; word uses addr[31:2] only.
  - The access proceeds force-aligned with no error.

Test Plan:
- WAIT_CYCLES=0; write word 0xDEADBEEF @0x1000_0000, then read @0x1000_0000 -> rsp_ready pulses 1 cycle after read acceptance, rsp_data=0xDEADBEEF, rsp_error=0.
- Byte write data=0x5A5A5A5A size=0 @0x1000_0003 after word 0x11223344 -> read returns 0x5A223344; half write 0xA5A5A5A5 @0x1000_0002 -> read returns 0xA5A53344.
- WAIT_CYCLES=3; read accepted at cycle 10 -> cmd_ready=0 cycles 11-14, rsp_ready=1 at cycle 14 only, next command accepted at cycle 15.
- Read @0x0FFF_FFFC and @0x1000_1000 (SIZE_BYTES=4096) -> rsp_error=1, rsp_data=0, err_sticky=1; write @0x1000_1000 -> RAM unchanged, err_sticky stays 1 until arst.
- Assert arst during WAIT after read accepted -> no rsp_ready pulse ever; cmd_ready=0 during reset, 1 first cycle after release, err_sticky=0.
- DBUS_SLV_MISALIGN_ERR_EN defined: word read @0x1000_0002 -> rsp_error=1. Undefined: same read -> rsp_error=0, data of word @0x1000_0000.
